// File: rtl/fp_align_shifter.sv
// fp_align_shifter: two-stage FP addend alignment (compare/swap, then right-shift with GRS)
// Ports: clk/rst (sync, active-high); in_valid/in_ready + exp_a/exp_b/man_a/man_b operand pair;
//        out_valid/out_ready + exp_out, man_big, man_small, grs {G,R,S}, swapped (B had larger exp).
// Config: define FP_ALIGN_STICKY_EN to compute guard/round/sticky; otherwise grs is 000 and
//         shifted-out bits are simply truncated.
module fp_align_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [23:0] man_a,
    input  logic [23:0] man_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic [23:0] man_big,
    output logic [23:0] man_small,
    output logic [2:0]  grs,
    output logic        swapped
);
    logic        s1_valid;
    logic        s1_swapped;
    logic [7:0]  s1_exp;
    logic [23:0] s1_big;
    logic [23:0] s1_small;
    logic [4:0]  s1_amt;
    logic        adv1;
    logic        adv2;
    logic        b_gt;
    logic [7:0]  diff;
    logic [4:0]  amt;
    logic [23:0] small_sh;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // Shift distance saturates at 27: beyond that every bit of {small,GRS} is gone.
    always_comb begin
        b_gt = exp_b > exp_a;
        diff = b_gt ? exp_b - exp_a : exp_a - exp_b;
        amt  = diff > 8'd27 ? 5'd27 : diff[4:0];
    end

`ifdef FP_ALIGN_STICKY_EN
    logic [26:0] ext;
    logic [26:0] lost_mask;
    logic [2:0]  grs_nxt;

    // lost_mask covers the amt low bits of {small,000} that fall off the bottom.
    always_comb begin
        ext       = {s1_small, 3'b000} >> s1_amt;
        lost_mask = 27'((28'd1 << s1_amt) - 28'd1);
        small_sh  = ext[26:3];
        grs_nxt   = {ext[2], ext[1], ext[0] | (|({s1_small, 3'b000} & lost_mask))};
    end

    always_ff @(posedge clk) begin
        if (rst)
            grs <= 3'b000;
        else if (adv2 && s1_valid)
            grs <= grs_nxt;
    end
`else
    always_comb small_sh = s1_small >> s1_amt;

    assign grs = 3'b000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            exp_out   <= 8'd0;
            man_big   <= 24'd0;
            man_small <= 24'd0;
            swapped   <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_swapped <= b_gt;
                    s1_exp     <= b_gt ? exp_b : exp_a;
                    s1_big     <= b_gt ? man_b : man_a;
                    s1_small   <= b_gt ? man_a : man_b;
                    s1_amt     <= amt;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    exp_out   <= s1_exp;
                    man_big   <= s1_big;
                    man_small <= small_sh;
                    swapped   <= s1_swapped;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_align_shifter.sv
// tb_fp_align_shifter: directed self-checking bench for fp_align_shifter
module tb_fp_align_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  exp_a = 8'd0;
    logic [7:0]  exp_b = 8'd0;
    logic [23:0] man_a = 24'd0;
    logic [23:0] man_b = 24'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  exp_out;
    logic [23:0] man_big;
    logic [23:0] man_small;
    logic [2:0]  grs;
    logic        swapped;

    int n_chk = 0;
    int n_fail = 0;

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  ea;
        logic [23:0] ma;
        logic [7:0]  eb;
        logic [23:0] mb;
        logic [7:0]  xe;
        logic [23:0] xb;
        logic [23:0] xs;
        logic [2:0]  xg;
        logic        xsw;
    } vec_t;

    fp_align_shifter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
        .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
        .man_big(man_big), .man_small(man_small), .grs(grs), .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] ea, input logic [23:0] ma, input logic [7:0] eb, input logic [23:0] mb);
        exp_a = ea; man_a = ma; exp_b = eb; man_b = mb; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        n_chk++; if ({exp_out, man_big, man_small, grs, swapped} !== 60'd0) begin n_fail++; $display("FAIL reset outputs got %h/%h/%h/%b/%b want zeros", exp_out, man_big, man_small, grs, swapped); end
        rst = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        vec_t v[10];
        logic [2:0] xg;
        v[0] = '{8'h80, 24'h800000, 8'h7E, 24'hC00000, 8'h80, 24'h800000, 24'h300000, 3'b000, 1'b0};
        v[1] = '{8'h7F, 24'h800000, 8'h81, 24'hA00000, 8'h81, 24'hA00000, 24'h200000, 3'b000, 1'b1};
        v[2] = '{8'h80, 24'h800000, 8'h7F, 24'h800001, 8'h80, 24'h800000, 24'h400000, 3'b100, 1'b0};
        v[3] = '{8'h9A, 24'h800000, 8'h7F, 24'h800001, 8'h9A, 24'h800000, 24'h000000, 3'b001, 1'b0};
        v[4] = '{8'hFF, 24'hC00000, 8'h00, 24'hFFFFFF, 8'hFF, 24'hC00000, 24'h000000, 3'b001, 1'b0};
        v[5] = '{8'h85, 24'h900000, 8'h85, 24'hABCDEF, 8'h85, 24'h900000, 24'hABCDEF, 3'b000, 1'b0};
        v[6] = '{8'h70, 24'h000000, 8'h80, 24'h000000, 8'h80, 24'h000000, 24'h000000, 3'b000, 1'b1};
        v[7] = '{8'h84, 24'h800000, 8'h80, 24'h800003, 8'h84, 24'h800000, 24'h080000, 3'b001, 1'b0};
        v[8] = '{8'h83, 24'h800000, 8'h80, 24'h800006, 8'h83, 24'h800000, 24'h100000, 3'b110, 1'b0};
        v[9] = '{8'h10, 24'hFFFFFF, 8'h50, 24'h800000, 8'h50, 24'h800000, 24'h000000, 3'b001, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            xg = STICKY ? v[i].xg : 3'b000;
            drive(v[i].ea, v[i].ma, v[i].eb, v[i].mb);
            tick();
            in_valid = 1'b0;
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d early out_valid got %b want 0", i, out_valid); end
            tick();
            n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d out_valid got %b want 1", i, out_valid); end
            n_chk++; if (exp_out !== v[i].xe) begin n_fail++; $display("FAIL dir%0d exp_out got %h want %h", i, exp_out, v[i].xe); end
            n_chk++; if (man_big !== v[i].xb) begin n_fail++; $display("FAIL dir%0d man_big got %h want %h", i, man_big, v[i].xb); end
            n_chk++; if (man_small !== v[i].xs) begin n_fail++; $display("FAIL dir%0d man_small got %h want %h", i, man_small, v[i].xs); end
            n_chk++; if (grs !== xg) begin n_fail++; $display("FAIL dir%0d grs got %b want %b", i, grs, xg); end
            n_chk++; if (swapped !== v[i].xsw) begin n_fail++; $display("FAIL dir%0d swapped got %b want %b", i, swapped, v[i].xsw); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] xs;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(8'h80, 24'h800000, 8'(8'h80 - c), 24'h800000);
            else in_valid = 1'b0;
            #1;
            n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b c%0d in_ready got %b want 1", c, in_ready); end
            tick();
            if (c >= 1 && c <= 4) begin
                xs = 24'h800000 >> (c - 1);
                n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b c%0d out_valid got %b want 1", c, out_valid); end
                n_chk++; if (man_small !== xs) begin n_fail++; $display("FAIL b2b c%0d man_small got %h want %h", c, man_small, xs); end
            end
        end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drain out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [23:0] xs[3];
        xs[0] = 24'h600000; xs[1] = 24'h300000; xs[2] = 24'h180000;
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            drive(8'h80, 24'h800000, 8'(8'h7F - p), 24'hC00000);
            #1;
            n_chk++; if (in_ready !== (p < 2)) begin n_fail++; $display("FAIL bp offer%0d in_ready got %b want %b", p, in_ready, p < 2); end
            if (p < 2) tick();
        end
        for (int h = 0; h < 3; h++) begin
            tick();
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp hold%0d in_ready got %b want 0", h, in_ready); end
            n_chk++; if (out_valid !== 1'b1 || man_small !== xs[0] || exp_out !== 8'h80) begin n_fail++; $display("FAIL bp hold%0d out got v=%b %h/%h want v=1 80/%h", h, out_valid, exp_out, man_small, xs[0]); end
        end
        out_ready = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (out_valid !== 1'b1 || man_small !== xs[k]) begin n_fail++; $display("FAIL bp drain%0d got v=%b %h want v=1 %h", k, out_valid, man_small, xs[k]); end
            tick();
            in_valid = 1'b0;
        end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp empty out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(8'h10, 24'h123456, 8'h20, 24'h654321);
        tick();
        drive(8'h11, 24'h111111, 8'h22, 24'h222222);
        tick();
        n_chk++; if (out_valid !== 1'b1 || swapped !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst fill got v=%b sw=%b rdy=%b want 1/1/0", out_valid, swapped, in_ready); end
        rst = 1'b1;
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
        n_chk++; if ({exp_out, man_big, man_small, grs, swapped} !== 60'd0) begin n_fail++; $display("FAIL midrst outputs got %h/%h/%h/%b/%b want zeros", exp_out, man_big, man_small, grs, swapped); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst flushed%0d out_valid got %b want 0", k, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_align_shifter.md
FP_ALIGN_SHIFTER -- requirements
Module: fp_align_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  block accepts the operand pair this cycle.
REQ-006 exp_a, exp_b  input  8  biased exponents.
REQ-007 man_a, man_b  input  24  mantissas; bit 23 is the hidden bit.
REQ-008 out_valid  output  1  aligned result present.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 exp_out  output  8  common (larger) exponent.
REQ-011 man_big  output  24  mantissa of the larger-exponent operand, unshifted.
REQ-012 man_small  output  24  mantissa of the smaller-exponent operand, right-shifted.
REQ-013 grs  output  3  guard, round and sticky bits, in the order {G,R,S}.
REQ-014 swapped  output  1  set to 1 when operand B had the larger exponent.

Function
REQ-015 A transfer SHALL occur on any edge where valid=1 and ready=1, on either side.
REQ-016 Stage 1 (compare/swap) SHALL work as follows:
- If exp_b > exp_a: big = B, small = A, swapped = 1.
- Otherwise (equal exponents included): big = A, small = B, swapped = 0.
- amt = |exp_a - exp_b|, saturated to 27.
- Register big, small, amt, swapped and the exponent.
REQ-017 Stage 2 (shift) SHALL work as follows:
- ext[26:0] = {small, 3'b000} >> amt.
- man_small = ext[26:3].
- G = ext[2], R = ext[1].
- S = ext[0] OR (OR of all bits shifted out below ext[0]).
- Register all outputs.
REQ-018 Latency SHALL be exactly 2 cycles from the input transfer to out_valid when out_ready is held high.
REQ-019 Throughput SHALL be one transfer per cycle when out_ready is held high.
REQ-020 Stage 2 SHALL advance when out_valid=0 or out_ready=1.
REQ-021 Stage 1 SHALL advance when its register is empty or stage 2 advances.
REQ-022 in_ready SHALL equal the stage-1 advance condition, combinationally.
REQ-023 While out_valid=1 and out_ready=0, all outputs SHALL remain stable.
REQ-024 Results SHALL leave in input order; no result is dropped or duplicated.
REQ-025 amt=0 SHALL give man_small=small and grs=000.
REQ-026 amt>=27 SHALL give man_small=0 and grs={0,0,|small}.
REQ-027 Zero operands (mantissa 0) SHALL pass through with no special casing.

Reset
REQ-028 On a clock edge with rst=1:
- out_valid and both stage valid flags clear to 0.
- exp_out, man_big, man_small, grs and swapped clear to 0.
REQ-029 rst SHALL take priority over any transfer in the same cycle; in-flight operands are discarded.
REQ-030 in_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-031 With macro FP_ALIGN_STICKY_EN defined, grs SHALL be computed as in REQ-017.
REQ-032 Without FP_ALIGN_STICKY_EN:
- grs SHALL be constant 000.
- Bits shifted out SHALL be truncated with no OR-reduction logic.
- man_small is unchanged.

Verification
REQ-033 Basic shift: exp_a=0x80, man_a=0x800000, exp_b=0x7E, man_b=0xC00000 -> 2 cycles later exp_out=0x80, man_big=0x800000, man_small=0x300000, grs=000, swapped=0.
REQ-034 Swap: exp_a=0x7F, man_a=0x800000, exp_b=0x81, man_b=0xA00000 -> exp_out=0x81, man_big=0xA00000, man_small=0x200000, swapped=1.
REQ-035 Guard bit: exp_a=0x80, exp_b=0x7F, man_b=0x800001 -> man_small=0x400000, grs=100 (000 without FP_ALIGN_STICKY_EN).
REQ-036 Saturated shift: exp_a=0x9A, exp_b=0x7F (diff 27), man_b=0x800001 -> man_small=0, grs=001 (000 without the macro).
REQ-037 Backpressure: out_ready=0 while 3 pairs are offered back-to-back -> expected response:
- Two pairs are accepted and in_ready drops to 0 on the third.
- Outputs stay stable.
- After out_ready=1, all 3 results emerge in order with no loss.
REQ-038 Reset mid-flight: assert rst for 1 cycle with both stages full -> next cycle out_valid=0 and all outputs 0; cycle after reset deasserts, in_ready=1.
